// File: rtl/cb_hash_pipe.sv
// Seeded multi-hash stage for the counting bloom filter: two elastic register stages
// producing bucket indices, one-hot mask and collision flag. CB_HASH_PIPE_STATS_EN adds beat/collision counters.
package cb_filter_pkg;
    typedef struct packed {
        logic [31:0] PermuteSeed;
        logic [31:0] XorSeed;
    } cb_seed_t;

    localparam cb_seed_t [2:0] EgSeeds = {
        cb_seed_t'{PermuteSeed: 32'd29, XorSeed: 32'hA5C3_961E},
        cb_seed_t'{PermuteSeed: 32'd11, XorSeed: 32'h3C5A_F00F},
        cb_seed_t'{PermuteSeed: 32'd5,  XorSeed: 32'h1234_5678}
    };
endpackage

module cb_hash_lane #(
    parameter int          InpWidth    = 32,
    parameter int          HashWidth   = 4,
    parameter logic [31:0] PermuteSeed = 32'd0,
    parameter logic [31:0] XorSeed     = 32'd0
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 ld_i,
    input  logic [InpWidth-1:0]  data_i,
    output logic [HashWidth-1:0] idx_o
);
    localparam int NCh = (InpWidth + HashWidth - 1) / HashWidth;
    localparam int Rot = int'(PermuteSeed % InpWidth);

    function automatic logic [InpWidth-1:0] rep_seed(input logic [31:0] s);
        logic [InpWidth-1:0] k;
        for (int i = 0; i < InpWidth; i++) k[i] = s[i % 32];
        return k;
    endfunction

    localparam logic [InpWidth-1:0] Key = rep_seed(XorSeed);

    logic [2*InpWidth-1:0]     rot_w;
    logic [InpWidth-1:0]       x_d, x_q;
    logic [NCh*HashWidth-1:0]  pad;

    // Upper half of the doubled word shifted left is the left rotation.
    assign rot_w = {data_i, data_i} << Rot;
    assign x_d   = rot_w[2*InpWidth-1 -: InpWidth] ^ Key;

    always_ff @(posedge clk_i) begin
        if (rst_i)     x_q <= '0;
        else if (ld_i) x_q <= x_d;
    end

    always_comb begin
        pad = '0;
        pad[InpWidth-1:0] = x_q;
        idx_o = '0;
        for (int c = 0; c < NCh; c++) idx_o ^= pad[c*HashWidth +: HashWidth];
    end
endmodule

module cb_hash_pipe #(
    parameter int NoHashes  = 3,
    parameter int InpWidth  = 32,
    parameter int HashWidth = 4,
    parameter cb_filter_pkg::cb_seed_t [NoHashes-1:0] Seeds = cb_filter_pkg::EgSeeds
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          valid_i,
    output logic                          ready_o,
    input  logic [InpWidth-1:0]           data_i,
    output logic                          valid_o,
    input  logic                          ready_i,
    output logic [NoHashes*HashWidth-1:0] idx_o,
    output logic [2**HashWidth-1:0]       mask_o,
    output logic                          coll_o,
    output logic [31:0]                   beats_o,
    output logic [31:0]                   colls_o
);
    localparam int Stages  = 2;
    localparam int IdxW    = NoHashes * HashWidth;
    localparam int Buckets = 2**HashWidth;

    logic [Stages:1]    vld_pipe_d, vld_pipe_q;
    logic               ld1, ld2, take;
    logic [IdxW-1:0]    idx_d, idx_q;
    logic [Buckets-1:0] mask_d, mask_q;
    logic               coll_d, coll_q;

    assign take    = vld_pipe_q[2] && ready_i;
    assign ld2     = vld_pipe_q[1] && (!vld_pipe_q[2] || ready_i);
    assign ready_o = !vld_pipe_q[1] || !vld_pipe_q[2] || ready_i;
    assign ld1     = valid_i && ready_o;

    always_comb begin
        vld_pipe_d[1] = ld1 || (vld_pipe_q[1] && !ld2);
        vld_pipe_d[2] = ld2 || (vld_pipe_q[2] && !take);
    end

    // Stage 1 lives inside each lane; its fold output feeds stage 2.
    for (genvar h = 0; h < NoHashes; h++) begin : g_lane
        cb_hash_lane #(
            .InpWidth   (InpWidth),
            .HashWidth  (HashWidth),
            .PermuteSeed(Seeds[h].PermuteSeed),
            .XorSeed    (Seeds[h].XorSeed)
        ) u_lane (
            .clk_i (clk_i),
            .rst_i (rst_i),
            .ld_i  (ld1),
            .data_i(data_i),
            .idx_o (idx_d[h*HashWidth +: HashWidth])
        );
    end

    always_comb begin
        mask_d = '0;
        for (int h = 0; h < NoHashes; h++) mask_d[idx_d[h*HashWidth +: HashWidth]] = 1'b1;
        coll_d = ($countones(mask_d) < NoHashes);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_pipe_q <= '0;
            idx_q      <= '0;
            mask_q     <= '0;
            coll_q     <= 1'b0;
        end else begin
            vld_pipe_q <= vld_pipe_d;
            if (ld2) begin
                idx_q  <= idx_d;
                mask_q <= mask_d;
                coll_q <= coll_d;
            end
        end
    end

    assign valid_o = vld_pipe_q[2];
    assign idx_o   = idx_q;
    assign mask_o  = mask_q;
    assign coll_o  = coll_q;

`ifdef CB_HASH_PIPE_STATS_EN
    logic [31:0] beats_d, beats_q, colls_d, colls_q;

    assign beats_d = take ? beats_q + 32'd1 : beats_q;
    assign colls_d = (take && coll_q) ? colls_q + 32'd1 : colls_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            beats_q <= '0;
            colls_q <= '0;
        end else begin
            beats_q <= beats_d;
            colls_q <= colls_d;
        end
    end

    assign beats_o = beats_q;
    assign colls_o = colls_q;
`else
    assign beats_o = '0;
    assign colls_o = '0;
`endif
endmodule

// File: tb/tb_cb_hash_pipe.sv
// Scoreboard bench for cb_hash_pipe: default pipe under stream/stall/reset plus
// small instances for single-hash, collision and fold-padding cases.
module tb_cb_hash_pipe;
    import cb_filter_pkg::*;

    localparam cb_seed_t [0:0] OneSeeds  = {cb_seed_t'{PermuteSeed: 32'd3,  XorSeed: 32'h0000_000F}};
    localparam cb_seed_t [1:0] ColSeeds  = {cb_seed_t'{PermuteSeed: 32'd7,  XorSeed: 32'hDEAD_BEEF},
                                            cb_seed_t'{PermuteSeed: 32'd7,  XorSeed: 32'hDEAD_BEEF}};
    localparam cb_seed_t [0:0] WrapSeeds = {cb_seed_t'{PermuteSeed: 32'd13, XorSeed: 32'h0000_0155}};

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst = 1'b1;

    logic        m_vi = 0, m_ro, m_vo, m_ri = 1, m_coll;
    logic [31:0] m_d = '0, m_beats, m_colls;
    logic [11:0] m_idx;
    logic [15:0] m_mask;

    logic        a_vi = 0, a_ro, a_vo, a_ri = 1, a_coll;
    logic [7:0]  a_d = '0;
    logic [3:0]  a_idx;
    logic [15:0] a_mask;
    logic [31:0] a_beats, a_colls;

    logic        b_vi = 0, b_ro, b_vo, b_ri = 1, b_coll;
    logic [31:0] b_d = '0, b_beats, b_colls;
    logic [7:0]  b_idx;
    logic [15:0] b_mask;

    logic        c_vi = 0, c_ro, c_vo, c_ri = 1, c_coll;
    logic [9:0]  c_d = '0;
    logic [3:0]  c_idx;
    logic [15:0] c_mask;
    logic [31:0] c_beats, c_colls;

    cb_hash_pipe u_dut (
        .clk_i(clk), .rst_i(rst), .valid_i(m_vi), .ready_o(m_ro), .data_i(m_d),
        .valid_o(m_vo), .ready_i(m_ri), .idx_o(m_idx), .mask_o(m_mask), .coll_o(m_coll),
        .beats_o(m_beats), .colls_o(m_colls));

    cb_hash_pipe #(.NoHashes(1), .InpWidth(8), .HashWidth(4), .Seeds(OneSeeds)) u_one (
        .clk_i(clk), .rst_i(rst), .valid_i(a_vi), .ready_o(a_ro), .data_i(a_d),
        .valid_o(a_vo), .ready_i(a_ri), .idx_o(a_idx), .mask_o(a_mask), .coll_o(a_coll),
        .beats_o(a_beats), .colls_o(a_colls));

    cb_hash_pipe #(.NoHashes(2), .InpWidth(32), .HashWidth(4), .Seeds(ColSeeds)) u_col (
        .clk_i(clk), .rst_i(rst), .valid_i(b_vi), .ready_o(b_ro), .data_i(b_d),
        .valid_o(b_vo), .ready_i(b_ri), .idx_o(b_idx), .mask_o(b_mask), .coll_o(b_coll),
        .beats_o(b_beats), .colls_o(b_colls));

    cb_hash_pipe #(.NoHashes(1), .InpWidth(10), .HashWidth(4), .Seeds(WrapSeeds)) u_wrap (
        .clk_i(clk), .rst_i(rst), .valid_i(c_vi), .ready_o(c_ro), .data_i(c_d),
        .valid_o(c_vo), .ready_i(c_ri), .idx_o(c_idx), .mask_o(c_mask), .coll_o(c_coll),
        .beats_o(c_beats), .colls_o(c_colls));

    int checks = 0, failures = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Bit-level reference: rotate, xor with repeated seed, fold by bit position.
    function automatic logic [15:0] mdl_hash(input logic [63:0] d, input int w, input int hw,
                                             input cb_seed_t s);
        int r;
        logic [63:0] p, x;
        logic [15:0] idx;
        r = int'(s.PermuteSeed % 32'(w));
        p = '0; x = '0; idx = '0;
        for (int i = 0; i < w; i++) p[(i + r) % w] = d[i];
        for (int i = 0; i < w; i++) x[i] = p[i] ^ s.XorSeed[i % 32];
        for (int i = 0; i < w; i++) idx[i % hw] ^= x[i];
        return idx;
    endfunction

    function automatic logic [28:0] mdl_main(input logic [31:0] d);
        logic [11:0] idx;
        logic [15:0] m, t;
        logic        coll;
        m = '0;
        for (int h = 0; h < 3; h++) begin
            t = mdl_hash({32'd0, d}, 32, 4, EgSeeds[h]);
            idx[h*4 +: 4] = t[3:0];
            m[t[3:0]] = 1'b1;
        end
        coll = ($countones(m) < 3);
        return {idx, m, coll};
    endfunction

    logic [28:0] sb_q[$];
    logic [28:0] last_out, exp_out;
    logic        stall_q = 0, saw_rdy_low = 0, rdy_drop = 0, tput_on = 0;
    int occ = 0, acc_n = 0, take_n = 0, coll_n = 0, cyc = 0;
    int first_acc_cyc = -1, first_vo_cyc = -1, last_take_cyc = -1;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            sb_q.delete();
            occ = 0; acc_n = 0; take_n = 0; coll_n = 0; stall_q = 0;
            first_acc_cyc = -1; first_vo_cyc = -1; last_take_cyc = -1;
        end else begin
            chk("ready_o", m_ro, !(occ == 2 && !m_ri));
            if (!m_ro) saw_rdy_low = 1;
            if (tput_on && !m_ro) rdy_drop = 1;
            if (stall_q) chk("stall_hold", {m_vo, m_idx, m_mask, m_coll}, {1'b1, last_out});
            if (m_vo && first_vo_cyc < 0) first_vo_cyc = cyc;
            if (m_vo && m_ri) begin
                chk("sb_nonempty", sb_q.size() != 0, 1);
                if (sb_q.size() != 0) begin
                    exp_out = sb_q.pop_front();
                    chk("out", {m_idx, m_mask, m_coll}, exp_out);
                end
                take_n++;
                last_take_cyc = cyc;
                if (m_coll) coll_n++;
            end
            if (m_vi && m_ro) begin
                sb_q.push_back(mdl_main(m_d));
                acc_n++;
                if (acc_n == 1) first_acc_cyc = cyc;
            end
            occ += (m_vi && m_ro) ? 1 : 0;
            occ -= (m_vo && m_ri) ? 1 : 0;
            stall_q  = m_vo && !m_ri;
            last_out = {m_idx, m_mask, m_coll};
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        m_vi = 0; rst = 1;
        @(posedge clk); #1;
        rst = 0;
    endtask

    task automatic wait_takes(input int n, input int budget);
        for (int i = 0; i < budget && take_n < n; i++) begin
            @(negedge clk); #1;
        end
        chk("take_count", take_n, n);
    endtask

    logic [15:0] exp16;
    logic [31:0] words [10];
    int k;
    logic stats;

    initial begin
`ifdef CB_HASH_PIPE_STATS_EN
        stats = 1;
`else
        stats = 0;
`endif
        repeat (2) @(posedge clk);
        #1 rst = 0;

        // reset state
        @(negedge clk);
        chk("rst_valid", m_vo, 0);
        chk("rst_idx_mask_coll", {m_idx, m_mask, m_coll}, 0);
        chk("rst_ready", m_ro, 1);
        chk("rst_counters", {m_beats, m_colls}, 0);

        // single hash: 0x81 rot3 -> 0x0C, ^0x0F -> 0x03, fold -> 3
        @(posedge clk); #1 a_vi = 1; a_d = 8'h81;
        @(negedge clk); chk("one_ready", a_ro, 1);
        @(posedge clk); #1 a_vi = 0;
        @(negedge clk); chk("one_lat1", a_vo, 0);
        @(negedge clk);
        chk("one_valid", a_vo, 1);
        exp16 = mdl_hash(64'h81, 8, 4, OneSeeds[0]);
        chk("one_idx_model", a_idx, exp16[3:0]);
        chk("one_idx", a_idx, 4'd3);
        chk("one_mask", a_mask, 16'h0008);
        chk("one_coll", a_coll, 0);

        // identical seeds always collide
        @(posedge clk); #1 b_vi = 1; b_d = $urandom;
        @(posedge clk); #1 b_vi = 0;
        @(negedge clk);
        @(negedge clk);
        chk("col_valid", b_vo, 1);
        chk("col_idx_eq", b_idx[3:0], b_idx[7:4]);
        chk("col_popcnt", $countones(b_mask), 1);
        chk("col_coll", b_coll, 1);
        @(negedge clk);
        chk("col_taken", b_vo, 0);
        chk("col_colls", b_colls, stats ? 32'd1 : 32'd0);

        // fold with a zero-padded 2-bit top chunk: x = 0x2AA -> A^A^2 = 2
        @(posedge clk); #1 c_vi = 1; c_d = 10'h3FF;
        @(posedge clk); #1 c_vi = 0;
        @(negedge clk);
        @(negedge clk);
        chk("wrap_valid", c_vo, 1);
        exp16 = mdl_hash(64'h3FF, 10, 4, WrapSeeds[0]);
        chk("wrap_idx_model", c_idx, exp16[3:0]);
        chk("wrap_idx", c_idx, 4'd2);
        chk("wrap_mask", c_mask, 16'h0004);

        // backpressure: 10 words, ready_i low for cycles 3..7
        do_reset();
        for (int i = 0; i < 10; i++) words[i] = $urandom;
        k = 0;
        saw_rdy_low = 0;
        for (int t = 0; t < 200 && k < 10; t++) begin
            @(posedge clk); #1;
            m_ri = !(t >= 3 && t <= 7);
            m_vi = 1;
            m_d  = words[k];
            @(negedge clk);
            if (m_ro) k++;
        end
        @(posedge clk); #1 m_vi = 0; m_ri = 1;
        chk("bp_sent", k, 10);
        wait_takes(10, 50);
        chk("bp_accepts", acc_n, 10);
        chk("bp_ready_low", saw_rdy_low, 1);

        // throughput: 100 beats back-to-back
        do_reset();
        rdy_drop = 0;
        tput_on = 1;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1 m_vi = 1; m_d = $urandom;
        end
        @(posedge clk); #1 m_vi = 0;
        tput_on = 0;
        wait_takes(100, 300);
        chk("tp_accepts", acc_n, 100);
        chk("tp_ready_never_low", rdy_drop, 0);
        chk("tp_latency", first_vo_cyc - first_acc_cyc, 2);
        chk("tp_cycles", last_take_cyc - first_acc_cyc + 1, 102);
        chk("tp_beats", m_beats, stats ? 32'd100 : 32'd0);
        chk("tp_colls", m_colls, stats ? 32'(coll_n) : 32'd0);

        // reset with both stages full
        @(posedge clk); #1 m_ri = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1 m_vi = 1; m_d = $urandom;
        end
        @(negedge clk);
        chk("mid_full_ready", m_ro, 0);
        chk("mid_full_valid", m_vo, 1);
        @(posedge clk); #1 m_vi = 0; rst = 1;
        @(posedge clk); #1 rst = 0; m_ri = 1;
        @(negedge clk);
        chk("mid_rst_valid", m_vo, 0);
        chk("mid_rst_mask", m_mask, 0);
        chk("mid_rst_ready", m_ro, 1);
        chk("mid_rst_counters", {m_beats, m_colls}, 0);
        @(posedge clk); #1 m_vi = 1; m_d = 32'hCAFE_F00D;
        @(posedge clk); #1 m_vi = 0;
        @(negedge clk); chk("mid_lat1", m_vo, 0);
        @(negedge clk); chk("mid_lat2", m_vo, 1);
        #1;
        wait_takes(1, 10);

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/cb_hash_pipe.md
Name: cb_hash_pipe

Overview:
- Pipelined, elastic hash stage that feeds the counting-bloom-filter counter array.
- Consumes one data word per handshake and applies NoHashes seeded hash functions, each configured by a cb_seed_t (PermuteSeed, XorSeed) from cb_filter_pkg.
- Emits per-hash bucket indices, the combined one-hot bucket mask, and a collision flag.
- Two register stages with full-throughput valid/ready backpressure.

Parameters:
- NoHashes, 3, number of hash functions (≥1).
- InpWidth, 32, input data width (≥HashWidth).
- HashWidth, 4, index width; bucket count = 2**HashWidth.
- Seeds, cb_filter_pkg::EgSeeds, cb_seed_t [NoHashes-1:0], per-hash seeds.

Ports:
- clk_i  in  1  clock; the block uses one clock, all logic on rising edge.
- rst_i  in  1  reset; synchronous and active-high.
- valid_i  in  1  input data valid.
- ready_o  out  1  stage can accept input.
- data_i  in  InpWidth  word to hash.
- valid_o  out  1  hash result valid.
- ready_i  in  1  downstream accepts result.
- idx_o  out  NoHashes*HashWidth  bucket index per hash; hash h occupies bits [h*HashWidth +: HashWidth].
- mask_o  out  2**HashWidth  OR of the one-hot decodes of all idx.
- coll_o  out  1  at least two hashes map to the same bucket.
- beats_o  out  32  accepted-beat counter (optional feature).
- colls_o  out  32  collision-beat counter (optional feature).

Behaviour:
- Hash h is a pure function of data_i:
  - p = data_i rotated left by (Seeds[h].PermuteSeed mod InpWidth).
  - x = p XOR K_h, where K_h is Seeds[h].XorSeed repeated from the LSB up and truncated to InpWidth.
  - idx_h = XOR of all HashWidth-bit chunks of x; the top chunk is zero-padded when InpWidth is not a multiple of HashWidth.
- Stage 1 registers x for all hashes plus valid. Stage 2 registers idx, mask, coll plus valid.
- Handshake:
  - Each stage loads when its input is valid and the stage is empty or its output is being taken this cycle.
  - ready_o = !s1_valid || (!s2_valid || ready_i).
- Throughput: 1 beat/cycle when ready_i stays high. Latency: 2 cycles from the accepting edge to valid_o.
- Stall (valid_o=1, ready_i=0):
  - idx_o/mask_o/coll_o/valid_o hold stable.
  - Stage 1 holds as well once full; no beat is dropped or duplicated.
- valid_o must not depend combinationally on ready_i. Once raised, valid_o stays high until the beat is taken.
- Simultaneous input accept and output take in the same cycle: both happen; occupancy is unchanged.
- coll_o = 1 iff popcount(mask_o) < NoHashes. coll_o is always 0 when NoHashes=1.
- Reset: rst_i high at an edge clears all valids and data registers to 0.
  - Outputs after reset: valid_o=0, idx_o=0, mask_o=0, coll_o=0, counters 0.
  - ready_o=1 after reset.
  - Beats in flight when reset asserts are discarded.
- Data registers are not required to load when their valid is 0.

Optional Feature:
- Macro: CB_HASH_PIPE_STATS_EN.
- Defined:
  - beats_o increments by 1 on every output handshake (valid_o && ready_i).
  - colls_o increments on every output handshake with coll_o=1.
  - Both counters wrap modulo 2**32 and clear on reset.
- Undefined: no counter flops; beats_o and colls_o tied to 0. All other behaviour is identical.

Test Plan:
- Single hash.
  - Config: NoHashes=1, InpWidth=8, HashWidth=4, PermuteSeed=3, XorSeed=8'h0F.
  - Stimulus: send 8'h81 with ready_i=1.
  - Required: valid_o rises 2 cycles later; idx_o=3, mask_o=16'h0008, coll_o=0.
- Collision.
  - Config: NoHashes=2, both seeds identical.
  - Stimulus: any input.
  - Required: idx fields equal, popcount(mask_o)=1, coll_o=1. With STATS_EN, colls_o=1 after the take.
- Backpressure.
  - Stimulus: default params; stream 10 random words with valid_i=1; ready_i low for cycles 3..7.
  - Required: exactly 10 outputs, in order, matching the software model; outputs stable while stalled; ready_o=0 while both stages are full.
- Throughput.
  - Stimulus: 100 back-to-back beats with ready_i=1.
  - Required: 100 outputs in 102 cycles; ready_o never drops. With STATS_EN, beats_o=100.
- Reset mid-stream.
  - Stimulus: assert rst_i for 1 cycle with both stages full.
  - Required: next cycle valid_o=0, mask_o=0, ready_o=1, counters 0; the first new beat appears 2 cycles after acceptance.
- Wrap/fold.
  - Config: InpWidth=10, HashWidth=4, PermuteSeed=13.
  - Stimulus: data 10'h3FF.
  - Required: rotation by 3 gives 10'h3FF; x = 10'h3FF ^ K_h; idx = fold including the zero-padded 2-bit top chunk, matching the model.
